// File: rtl/cu_sum_kernel_control_lanes.sv
// Multi-lane fixed-point SPMV pull sum kernel: vertex job FSM, lane multiply/reduce pipeline, FWFT result FIFO.
// Optional macro CU_SUM_KERNEL_CONTROL_SATURATE_EN: saturating accumulator plus sticky sat_flag output.
//
// state | meaning
// IDLE  | waiting for a vertex job (needs FIFO headroom)
// ACCUM | consuming edge beats until the degree is reached
// DRAIN | letting the multiply/reduce pipeline empty (3 cycles)
// PUSH  | writing {id, sum, CU ids} into the FIFO
module cu_sum_kernel_control_lanes #(
  parameter int CU_ID_X    = 1,
  parameter int CU_ID_Y    = 1,
  parameter int NUM_LANES  = 4,
  parameter int DATA_W     = 32,
  parameter int FRAC_BITS  = 16,
  parameter int VERTEX_W   = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clock,
  input  logic                          rstn_in,
  input  logic                          enabled_in,
  input  logic                          vertex_valid,
  input  logic [VERTEX_W-1:0]           vertex_id,
  input  logic [VERTEX_W-1:0]           vertex_degree,
  output logic                          vertex_ready,
  input  logic [NUM_LANES-1:0]          edge_valid,
  input  logic [NUM_LANES*DATA_W-1:0]   edge_data,
  input  logic [NUM_LANES*DATA_W-1:0]   edge_weight,
  output logic                          edge_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [VERTEX_W-1:0]           out_index,
  output logic [DATA_W-1:0]             out_data,
  output logic [7:0]                    out_cu_id_x,
  output logic [7:0]                    out_cu_id_y,
  output logic [VERTEX_W-1:0]           edge_count_total,
  output logic [VERTEX_W-1:0]           vertex_count_total,
  output logic                          overrun_err
`ifdef CU_SUM_KERNEL_CONTROL_SATURATE_EN
  ,
  output logic                          sat_flag
`endif
);

  localparam int PW    = DATA_W + 2;
  localparam int SW    = PW + $clog2(NUM_LANES);
  localparam int AW    = DATA_W + 8;
  localparam int FW    = 2 * DATA_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, PUSH} state_e;

  typedef struct packed {
    logic [VERTEX_W-1:0] idx;
    logic [DATA_W-1:0]   data;
    logic [7:0]          cu_x;
    logic [7:0]          cu_y;
  } entry_t;

  logic                 rstn, enabled_q;
  state_e               state_q, state_d;
  logic [VERTEX_W-1:0]  rem_q, rem_d, id_q, pcnt, take;
  logic [1:0]           drain_q;
  logic                 vtx_fire, edge_fire, push, pop;
  logic [NUM_LANES-1:0] keep;

  logic signed [PW-1:0] prod_c [NUM_LANES];
  logic signed [PW-1:0] prod_q [NUM_LANES];
  logic signed [SW-1:0] sum_c, sum_q;
  logic signed [AW-1:0] acc_c, acc_q;

  entry_t               mem_q [FIFO_DEPTH];
  entry_t               head;
  logic [PTR_W-1:0]     wr_q, rd_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  // rstn is rstn_in re-timed once; assertion stays asynchronous, release is clocked
  always_ff @(posedge clock or negedge rstn_in) begin
    if (!rstn_in) rstn <= 1'b0;
    else          rstn <= 1'b1;
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) enabled_q <= 1'b0;
    else       enabled_q <= enabled_in;
  end

  // vertex_ready/edge_ready are registered and already include enabled_q and the state
  assign vtx_fire  = vertex_valid && vertex_ready;
  assign edge_fire = edge_ready && (|edge_valid);
  assign pcnt      = VERTEX_W'($countones(edge_valid));
  assign take      = (pcnt > rem_q) ? rem_q : pcnt;
  assign push      = enabled_q && (state_q == PUSH);
  assign pop       = out_valid && out_ready;
  assign cnt_d     = cnt_q + CNT_W'(push) - CNT_W'(pop);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (enabled_q) begin
      unique case (state_q)
        IDLE: if (vtx_fire) begin
          rem_d   = vertex_degree;
          state_d = (vertex_degree == '0) ? PUSH : ACCUM;
        end
        ACCUM: if (edge_fire) begin
          rem_d = rem_q - take;
          if (rem_d == '0) state_d = DRAIN;
        end
        DRAIN: if (drain_q == 2'd0) state_d = PUSH;
        PUSH:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_q          <= IDLE;
      rem_q            <= '0;
      id_q             <= '0;
      drain_q          <= '0;
      vertex_ready     <= 1'b0;
      edge_ready       <= 1'b0;
      edge_count_total <= '0;
      overrun_err      <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      vertex_ready <= enabled_in && (state_d == IDLE) && (cnt_d < CNT_W'(FIFO_DEPTH - 2));
      edge_ready   <= enabled_in && (state_d == ACCUM) && (rem_d != '0);
      if (vtx_fire) id_q <= vertex_id;
      if (edge_fire) begin
        edge_count_total <= edge_count_total + take;
        if (pcnt > rem_q) overrun_err <= 1'b1;
      end
      if ((state_d == DRAIN) && (state_q != DRAIN)) drain_q <= 2'd2;
      else if ((state_q == DRAIN) && enabled_q && (drain_q != 2'd0)) drain_q <= drain_q - 2'd1;
    end
  end

  // edge_valid[i] is lane i; lane 0 data/weight sit in the MSBs
  always_comb begin
    keep = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      keep[i]   = edge_valid[i] && (VERTEX_W'(i) < rem_q);
      prod_c[i] = PW'((FW'($signed(edge_data[(NUM_LANES-1-i)*DATA_W +: DATA_W])) *
                       FW'($signed(edge_weight[(NUM_LANES-1-i)*DATA_W +: DATA_W]))) >>> FRAC_BITS);
    end
  end

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < NUM_LANES; i++) sum_c = sum_c + SW'(prod_q[i]);
  end

`ifdef CU_SUM_KERNEL_CONTROL_SATURATE_EN
  localparam logic signed [AW-1:0] SAT_MAX = (AW'(1) <<< (DATA_W - 1)) - AW'(1);
  localparam logic signed [AW-1:0] SAT_MIN = -(AW'(1) <<< (DATA_W - 1));
  logic signed [AW-1:0] acc_raw;
  logic                 sat_hit;
  always_comb begin
    acc_raw = acc_q + AW'(sum_q);
    acc_c   = acc_raw;
    sat_hit = 1'b0;
    if (acc_raw > SAT_MAX) begin
      acc_c   = SAT_MAX;
      sat_hit = 1'b1;
    end else if (acc_raw < SAT_MIN) begin
      acc_c   = SAT_MIN;
      sat_hit = 1'b1;
    end
  end
`else
  assign acc_c = acc_q + AW'(sum_q);
`endif

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_LANES; i++) prod_q[i] <= '0;
      sum_q <= '0;
      acc_q <= '0;
`ifdef CU_SUM_KERNEL_CONTROL_SATURATE_EN
      sat_flag <= 1'b0;
`endif
    end else if (enabled_q) begin
      for (int i = 0; i < NUM_LANES; i++) prod_q[i] <= (edge_fire && keep[i]) ? prod_c[i] : '0;
      sum_q <= sum_c;
      acc_q <= vtx_fire ? '0 : acc_c;
`ifdef CU_SUM_KERNEL_CONTROL_SATURATE_EN
      if (sat_hit && !vtx_fire) sat_flag <= 1'b1;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_q] <= '{idx: id_q, data: acc_q[DATA_W-1:0],
                               cu_x: 8'(CU_ID_X), cu_y: 8'(CU_ID_Y)};
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      wr_q               <= '0;
      rd_q               <= '0;
      cnt_q              <= '0;
      vertex_count_total <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push) wr_q <= wr_q + PTR_W'(1);
      if (pop) begin
        rd_q               <= rd_q + PTR_W'(1);
        vertex_count_total <= vertex_count_total + VERTEX_W'(1);
      end
    end
  end

  // Head fields are gated so an empty FIFO presents all zeros
  assign head        = mem_q[rd_q];
  assign out_valid   = (cnt_q != '0);
  assign out_index   = out_valid ? head.idx  : '0;
  assign out_data    = out_valid ? head.data : '0;
  assign out_cu_id_x = out_valid ? head.cu_x : '0;
  assign out_cu_id_y = out_valid ? head.cu_y : '0;

endmodule
